// File: rtl/niossoc_switch_pio_irq.sv
// rtl/niossoc_switch_pio_irq.sv - debounced switch/key PIO with edge capture, irq mask and level irq
module niossoc_switch_pio_irq #(
  parameter int unsigned WIDTH           = 18,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] TERM_CNT = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;

  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] deb_dly_q;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             wr_en;
  logic             unused_wdata;

  assign s            = sync_q[SYNC_STAGES-1];
  assign wr_en        = chipselect & ~write_n;
  // Bits above WIDTH have no register behind them.
  assign unused_wdata = ^writedata;

  // Metastability chain for the asynchronous switch inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Per-bit debounce: the count restarts whenever s falls back to the held value.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == TERM_CNT) begin
        deb_d[i] = s[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Debounced value, its one-cycle delayed copy and the per-bit counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q     <= '0;
      deb_dly_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Edge selection: 0 rising, 1 falling, anything else any change.
  always_comb begin
    edge_hit = deb_q & ~deb_dly_q;
    if (EDGE_TYPE == 1)      edge_hit = ~deb_q & deb_dly_q;
    else if (EDGE_TYPE == 2) edge_hit = deb_q ^ deb_dly_q;
  end

  // Register writes, W1C of edgecapture (a new edge beats a clear), read mux and irq.
  always_comb begin
    clr_mask   = '0;
    irqmask_d  = irqmask_q;
    readdata_d = '0;
    if (wr_en && address == 2'd3) clr_mask = writedata[WIDTH-1:0];
    if (wr_en && address == 2'd2) irqmask_d = writedata[WIDTH-1:0];
    edgecap_d = (edgecap_q & ~clr_mask) | edge_hit;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = deb_q;
      2'd1:    readdata_d[WIDTH-1:0] = s;
      2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
      default: readdata_d[WIDTH-1:0] = edgecap_q;
    endcase
    irq_d = |(edgecap_q & irqmask_q);
  end

  // Architectural registers visible on the slave port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap_q  <= '0;
      irqmask_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      edgecap_q  <= edgecap_d;
      irqmask_q  <= irqmask_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: doc/niossoc_switch_pio_irq.md
Name: niossoc_switch_pio_irq

Overview:
- Parametrised successor to the NiosSoc input PIO for the board slide switches and keys.
- Adds a configurable input synchroniser, per-bit debouncing, per-bit edge capture, an interrupt mask and a level IRQ output.
- Sits as an Avalon-MM slave (s1, read latency 1) on the Nios II data master, with `irq` routed to the CPU interrupt controller.

Parameters:
- WIDTH, 18: number of input channels; legal range 1..32.
- SYNC_STAGES, 2: flip-flop synchroniser depth on `in_port`; minimum 2.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before the debounced value changes; minimum 1 (1 = no filtering, one-register delay).
- EDGE_TYPE, 0: 0 = capture rising edges, 1 = falling, 2 = any change.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous switch/key inputs.
- irq  out  1  active-high level interrupt.

Behaviour:
- Interface: one clock `clk`; reset `reset_n` is asynchronous, active-low. All registers clear on reset: sync chain, debounced value `deb`, previous value `deb_d`, counters, irqmask, edgecapture, readdata. `irq` = 0 during and after reset.
- Synchroniser: `in_port` passes through SYNC_STAGES flops; the output is `s`.
- Debounce, per bit, counter width clog2(DEBOUNCE_CYCLES)+1:
  - if s==deb: cnt<=0.
  - else if cnt==DEBOUNCE_CYCLES-1: deb<=s, cnt<=0.
  - else: cnt<=cnt+1.
  - Any glitch back to `deb` restarts the count.
  - Total latency from a clean step on `in_port` to `deb` updating is SYNC_STAGES+DEBOUNCE_CYCLES cycles.
- Edge detection: deb_d<=deb every cycle. The edge term is computed from `deb` and `deb_d` per EDGE_TYPE (rise = deb&~deb_d, fall = ~deb&deb_d, any = deb^deb_d). An edge sets its edgecapture bit on the next clock.
- Register map (word addresses):
  - 0 data: read returns zero-extended `deb`; writes ignored.
  - 1 raw: read returns zero-extended `s` (pre-debounce); writes ignored.
  - 2 irqmask: read/write, bits [WIDTH-1:0]; upper bits read 0.
  - 3 edgecapture: read; writing 1 to a bit clears it (write-1-to-clear); writing 0 has no effect.
- Write strobe: chipselect==1 and write_n==0; it takes effect at that clock edge.
- Simultaneous clear-write and new edge on the same bit in the same cycle: the set wins and the bit stays 1.
- Read: readdata is updated every cycle from the address mux (registered, latency 1) regardless of chipselect. Bits [31:WIDTH] are always 0.
- IRQ: irq is registered, irq <= |(edgecapture & irqmask). It deasserts the cycle after the last masked captured bit is cleared or masked off.
- Reset mid-debounce: counters clear and `deb` returns to 0. After release, an input held high is re-debounced from zero and produces a fresh rising edge capture.
- Counter saturation cannot occur: the counter resets at the terminal count.

Test Plan (WIDTH=18, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_TYPE=0):
- Reset state: hold reset_n=0, in_port=18'h3FFFF, then release.
  - `irq` must read 0 and all readdata 0 during reset.
  - addr0 reads 0x3FFFF exactly 6 cycles after release.
  - Bits [31:18] must always read 0.
- Debounce glitch: in_port[0] high for 3 cycles, then low → addr0 stays 0x0 and edgecapture stays 0. Holding it high for 4+ cycles → addr0=0x00001 at cycle 6 after the rising step.
- Edge capture and IRQ: write irqmask=0x00005, then step in_port[2] 0→1 → edgecapture=0x00004 and irq=1 one cycle after the capture. Step in_port[1] 0→1 → edgecapture=0x00006 with irq unchanged.
- Write-1-to-clear: write 0x00004 to addr3 → edgecapture=0x00002 and irq=0 the next cycle. Write 0x00000 to addr3 → no change.
- Simultaneous set/clear: time a write of 0x00008 to addr3 on the exact cycle bit3's rising edge is detected → edgecapture[3]=1 after the write.
- Falling mode (EDGE_TYPE=1 build): a 1→0 step on bit 17 → edgecapture=0x20000; a 0→1 step captures nothing.
- Reset mid-operation: assert reset_n low while bit 0's counter=2 and edgecapture=0x00001 → all state cleared. After release with bit 0 held high, edgecapture=0x00001 again after 6+1 cycles.
